// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the 32-entry general-purpose register file.
//   DATA_WIDTH : width of every register and data port (64)
//   ADDR_WIDTH : register-address width (5, tied to the 5-to-32 decoder)
//   NUM_REGS   : number of architectural registers (32)
//   ZERO_REG   : index of the hardwired-zero register, XZR (31)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 31;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [63:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/decoder_5to32.sv
// -----------------------------------------------------------------------------
// decoder_5to32
// Existing 5-to-32 one-hot decoder used by the writeback path.
// Ports:
//   sel    : 5-bit select
//   enable : when low, every output is 0
//   out    : one-hot vector, bit sel set when enable is high
// -----------------------------------------------------------------------------
module decoder_5to32 (
    input  logic [4:0]  sel,
    input  logic        enable,
    output logic [31:0] out
);

    always_comb begin
        out = 32'd0;
        if (enable) begin
            out[sel] = 1'b1;
        end
    end

endmodule : decoder_5to32

// File: rtl/reg_cell.sv
// -----------------------------------------------------------------------------
// reg_cell
// One DATA_WIDTH-bit storage register with synchronous active-high clear and
// a load enable. Clear wins over load.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high clear
//   i_load : load enable
//   i_d    : data to load
//   o_q    : stored value
// -----------------------------------------------------------------------------
module reg_cell
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_q
);

    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : reg_cell

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 32 x DATA_WIDTH general-purpose register file: two combinational read ports,
// one synchronous write port, register ZERO_REG hardwired to zero (XZR).
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous active-high, clears every register; beats a write
//   read_reg1  : read port 1 address      read_data1 : contents of read_reg1
//   read_reg2  : read port 2 address      read_data2 : contents of read_reg2
//   write_reg  : write address
//   write_data : write data
//   reg_write  : write enable (gates the decoder enable)
// Build option:
//   REGFILE_BYPASS_EN : when defined, each read port forwards write_data in the
//                       same cycle as a matching write (not to XZR, not in
//                       reset). Undefined: reads return stored state only.
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    import regfile_pkg::*;

    // The read tree and decoder are both built for exactly 5 address bits.
    if (ADDR_WIDTH != 5) begin : g_bad_addr_width
        $error("reg_file: ADDR_WIDTH must be 5");
    end

    localparam logic [ADDR_WIDTH-1:0] LP_ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [NUM_REGS-1:0]   w_we;
    logic                  w_unused_zero_we;
    logic [DATA_WIDTH-1:0] w_regs  [NUM_REGS];
    logic [ADDR_WIDTH-1:0] w_raddr [2];
    logic [DATA_WIDTH-1:0] w_rdata [2];

    // Write decode: one-hot enable per register from the shared decoder.
    decoder_5to32 u_wdec (
        .sel    (write_reg),
        .enable (reg_write),
        .out    (w_we)
    );

    // XZR has no storage, so its enable bit goes nowhere.
    assign w_unused_zero_we = w_we[ZERO_REG];

    // Storage: one cell per register except the hardwired-zero slot.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        if (gi == ZERO_REG) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_cell
            reg_cell #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_cell (
                .clk    (clk),
                .reset  (reset),
                .i_load (w_we[gi]),
                .i_d    (write_data),
                .o_q    (w_regs[gi])
            );
        end
    end

    assign w_raddr[0] = read_reg1;
    assign w_raddr[1] = read_reg2;

    // Read ports: binary 2:1 mux tree, address LSB selects at the leaves.
    for (genvar gp = 0; gp < 2; gp++) begin : g_rport
        logic [DATA_WIDTH-1:0] w_l1 [16];
        logic [DATA_WIDTH-1:0] w_l2 [8];
        logic [DATA_WIDTH-1:0] w_l3 [4];
        logic [DATA_WIDTH-1:0] w_l4 [2];
        logic [DATA_WIDTH-1:0] w_l5;

        for (genvar gk = 0; gk < 16; gk++) begin : g_lvl1
            assign w_l1[gk] = w_raddr[gp][0] ? w_regs[2*gk+1] : w_regs[2*gk];
        end
        for (genvar gk = 0; gk < 8; gk++) begin : g_lvl2
            assign w_l2[gk] = w_raddr[gp][1] ? w_l1[2*gk+1] : w_l1[2*gk];
        end
        for (genvar gk = 0; gk < 4; gk++) begin : g_lvl3
            assign w_l3[gk] = w_raddr[gp][2] ? w_l2[2*gk+1] : w_l2[2*gk];
        end
        for (genvar gk = 0; gk < 2; gk++) begin : g_lvl4
            assign w_l4[gk] = w_raddr[gp][3] ? w_l3[2*gk+1] : w_l3[2*gk];
        end
        assign w_l5 = w_raddr[gp][4] ? w_l4[1] : w_l4[0];

`ifdef REGFILE_BYPASS_EN
        // Same-cycle forwarding of the writeback value to a matching reader.
        logic w_fwd;
        assign w_fwd = reg_write && !reset
                       && (write_reg == w_raddr[gp])
                       && (write_reg != LP_ZERO_ADDR);
        assign w_rdata[gp] = w_fwd ? write_data : w_l5;
`else
        assign w_rdata[gp] = w_l5;
`endif
    end

    assign read_data1 = w_rdata[0];
    assign read_data2 = w_rdata[1];

endmodule : reg_file

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [63:0] write_data;
    logic        reg_write;
    logic [63:0] read_data1, read_data2;

    int total = 0;
    int bad   = 0;

    logic [63:0] mem [32];
    bit          model_ok = 1'b0;

    reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    // Architectural model: what a read must return given stored state and
    // the inputs currently applied.
    function automatic logic [63:0] model_rd(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write && !reset && write_reg == a) return write_data;
`endif
        return mem[a];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] = 64'd0;
            model_ok = 1'b1;
        end else if (reg_write && write_reg != 5'd31) begin
            mem[write_reg] = write_data;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_rd1", read_data1, model_rd(read_reg1));
            chk("model_rd2", read_data2, model_rd(read_reg2));
        end
    end

    task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic en);
        @(posedge clk); #1;
        write_reg  = a;
        write_data = d;
        reg_write  = en;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        reg_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk); #1;
        read_reg1 = a1;
        read_reg2 = a2;
        #2;
    endtask

    initial begin
        logic [4:0]  a;
        logic [63:0] e;
        reset      = 1'b1;
        read_reg1  = 5'd0;
        read_reg2  = 5'd0;
        write_reg  = 5'd0;
        write_data = 64'd0;
        reg_write  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // All registers read zero after reset.
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            rd(a, 5'd31 - a);
            chk("reset_rd1", read_data1, 64'd0);
            chk("reset_rd2", read_data2, 64'd0);
        end

        // Write every storage register, then read them all back.
        for (int i = 0; i < 31; i++) wr(5'(i), 64'h1000 + 64'(i), 1'b1);
        idle();
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            e = (i == 31) ? 64'd0 : 64'h1000 + 64'(i);
            rd(a, a);
            chk("sweep_rd1", read_data1, e);
            chk("sweep_rd2", read_data2, e);
        end
        rd(5'd0, 5'd30);
        chk("sweep_r0", read_data1, 64'h1000);
        chk("sweep_r30", read_data2, 64'h101E);

        // Writes to XZR are discarded.
        wr(5'd31, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
        read_reg1 = 5'd31;
        read_reg2 = 5'd17;
        idle();
        #2;
        chk("xzr_rd", read_data1, 64'd0);
        chk("xzr_r17", read_data2, 64'h1011);
        for (int i = 0; i < 31; i++) begin
            a = 5'(i);
            rd(a, 5'd31);
            chk("xzr_other", read_data1, 64'h1000 + 64'(i));
            chk("xzr_rd2", read_data2, 64'd0);
        end

        // reg_write low: no update.
        wr(5'd5, 64'h55, 1'b0);
        idle();
        rd(5'd5, 5'd5);
        chk("gate_r5", read_data1, 64'h1005);

        // Same-cycle read/write on register 3.
        wr(5'd3, 64'hAAAA, 1'b1);
        idle();
        rd(5'd3, 5'd3);
        chk("rw_pre_store", read_data1, 64'hAAAA);
        wr(5'd3, 64'hBBBB, 1'b1);
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("rw_before1", read_data1, 64'hBBBB);
        chk("rw_before2", read_data2, 64'hBBBB);
`else
        chk("rw_before1", read_data1, 64'hAAAA);
        chk("rw_before2", read_data2, 64'hAAAA);
`endif
        idle();
        #2;
        chk("rw_after1", read_data1, 64'hBBBB);
        chk("rw_after2", read_data2, 64'hBBBB);

        // Reset beats a simultaneous write to register 7.
        rd(5'd7, 5'd9);
        chk("pre_rst_r7", read_data1, 64'h1007);
        @(posedge clk); #1;
        reset      = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd7;
        write_data = 64'h77;
        #2;
        chk("rst_wr_hold7", read_data1, 64'h1007);
        @(posedge clk); #1;
        reset     = 1'b0;
        reg_write = 1'b0;
        #2;
        chk("rst_prio_r7", read_data1, 64'd0);
        chk("rst_clr_r9", read_data2, 64'd0);
        rd(5'd3, 5'd30);
        chk("rst_clr_r3", read_data1, 64'd0);
        chk("rst_clr_r30", read_data2, 64'd0);

        // Write after reset still works on both ports.
        wr(5'd12, 64'h0123_4567_89AB_CDEF, 1'b1);
        idle();
        rd(5'd12, 5'd12);
        chk("post_rst_wr1", read_data1, 64'h0123_4567_89AB_CDEF);
        chk("post_rst_wr2", read_data2, 64'h0123_4567_89AB_CDEF);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file
